// File: rtl/chip8_reg_transfer.sv
`default_nettype none
// ============================================================================
// Module : chip8_reg_transfer
// Brief  : Moves V0..VX to or from memory at I (CHIP-8 FX55 / FX65),
//          two cycles per register, then produces the updated I.
// Rev    : 1.0  initial release
// ============================================================================
module chip8_reg_transfer #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  direction,
  input  logic [3:0]            last_reg,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] i_next,
  output logic [3:0]            rf_select_output,
  input  logic [7:0]            rf_output_data,
  output logic                  rf_write_enable,
  output logic [3:0]            rf_select_input,
  output logic [7:0]            rf_input_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_enable,
  input  logic [7:0]            mem_read_data,
  output logic                  mem_write_enable,
  output logic [7:0]            mem_write_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_RD = 3'd1,
    S_WR = 3'd2,
    L_RD = 3'd3,
    L_WR = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_idx;
  logic [3:0]              r_last;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_i_next;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [ADDR_WIDTH-1:0]   w_i_next;
  logic                    w_last_hit;

  // Address sums wrap naturally at the ADDR_WIDTH boundary.
  assign w_addr     = r_base + ADDR_WIDTH'(r_idx);
  assign w_i_next   = r_base + ADDR_WIDTH'(r_last) + ADDR_WIDTH'(1);
  assign w_last_hit = (r_idx == r_last);
  assign i_next     = r_i_next;

  // Direction is captured by the choice of S_* versus L_* branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_idx    <= 4'd0;
      r_last   <= 4'd0;
      r_base   <= '0;
      r_i_next <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_last <= last_reg;
            r_base <= base_addr;
            r_idx  <= 4'd0;
          end
        end
        S_WR, L_WR: begin
          if (w_last_hit) r_i_next <= w_i_next;
          else            r_idx    <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state     = r_state;
    busy             = (r_state != IDLE);
    done             = 1'b0;
    rf_select_output = 4'd0;
    rf_write_enable  = 1'b0;
    rf_select_input  = 4'd0;
    rf_input_data    = 8'd0;
    mem_addr         = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = 8'd0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = direction ? L_RD : S_RD;
      end
      S_RD: begin
        rf_select_output = r_idx;
        w_next_state     = S_WR;
      end
      S_WR: begin
        mem_write_enable = 1'b1;
        mem_addr         = w_addr;
        mem_write_data   = rf_output_data;
        w_next_state     = w_last_hit ? DONE : S_RD;
      end
      L_RD: begin
        mem_read_enable = 1'b1;
        mem_addr        = w_addr;
        w_next_state    = L_WR;
      end
      L_WR: begin
        rf_write_enable = 1'b1;
        rf_select_input = r_idx;
        rf_input_data   = mem_read_data;
        w_next_state    = w_last_hit ? DONE : L_RD;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_chip8_reg_transfer.sv
`default_nettype none
// ============================================================================
// Module : tb_chip8_reg_transfer
// Brief  : Scoreboard bench for chip8_reg_transfer with memory and register
//          file models; expected strobe events are queued at stimulus time.
// Rev    : 1.0  initial release
// ============================================================================
module tb_chip8_reg_transfer;

  localparam int AW = 12;
  localparam int K_MEMW = 0;
  localparam int K_MEMR = 1;
  localparam int K_RFW  = 2;
  localparam int K_DONE = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          direction;
  logic [3:0]    last_reg;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;
  logic [AW-1:0] i_next;
  logic [3:0]    rf_select_output;
  logic [7:0]    rf_output_data = 8'd0;
  logic          rf_write_enable;
  logic [3:0]    rf_select_input;
  logic [7:0]    rf_input_data;
  logic [AW-1:0] mem_addr;
  logic          mem_read_enable;
  logic [7:0]    mem_read_data = 8'd0;
  logic          mem_write_enable;
  logic [7:0]    mem_write_data;

  chip8_reg_transfer #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .direction        (direction),
    .last_reg         (last_reg),
    .base_addr        (base_addr),
    .busy             (busy),
    .done             (done),
    .i_next           (i_next),
    .rf_select_output (rf_select_output),
    .rf_output_data   (rf_output_data),
    .rf_write_enable  (rf_write_enable),
    .rf_select_input  (rf_select_input),
    .rf_input_data    (rf_input_data),
    .mem_addr         (mem_addr),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_m [0:4095];
  logic [7:0] rf_m  [0:15];
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable) mem_m[mem_addr] <= mem_write_data;
    if (mem_read_enable)  mem_read_data   <= mem_m[mem_addr];
    if (rf_write_enable)  rf_m[rf_select_input] <= rf_input_data;
    rf_output_data <= rf_m[rf_select_output];
  end

  typedef struct {
    int         kind;
    logic [11:0] addr;
    logic [7:0]  data;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  function automatic void push(input int kind, input logic [11:0] a,
                               input logic [7:0] d, input int c);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.cyc = c;
    sb.push_back(e);
  endfunction

  // Monitor: every strobe or done pulse must match the oldest queued event.
  always @(negedge clk) begin
    ev_t a;
    ev_t e;
    int  nstb;
    nstb = int'(mem_write_enable) + int'(mem_read_enable) + int'(rf_write_enable);
    if (nstb > 0 || done) begin
      if (nstb > 1) begin
        n_vec++; n_miss++;
        $display("FAIL strobe_onehot: %0d strobes high at cycle %0d, required at most 1", nstb, cyc);
      end
      a.data = 8'd0;
      if (done) begin
        a.kind = K_DONE; a.addr = i_next;
      end else if (mem_write_enable) begin
        a.kind = K_MEMW; a.addr = mem_addr; a.data = mem_write_data;
      end else if (mem_read_enable) begin
        a.kind = K_MEMR; a.addr = mem_addr;
      end else begin
        a.kind = K_RFW; a.addr = {8'd0, rf_select_input}; a.data = rf_input_data;
      end
      a.cyc = cyc;
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_event: kind %0d addr %h data %h cycle %0d, required none",
                 a.kind, a.addr, a.data, a.cyc);
      end else begin
        e = sb.pop_front();
        if (e.kind != a.kind || e.addr != a.addr || e.data != a.data || e.cyc != a.cyc) begin
          n_miss++;
          $display("FAIL event: got kind %0d addr %h data %h cycle %0d, required kind %0d addr %h data %h cycle %0d",
                   a.kind, a.addr, a.data, a.cyc, e.kind, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following rising edge.
  task automatic start_xfer(input logic dir, input int x, input logic [11:0] base,
                            input logic [11:0] exp_inext, output int k);
    k         = cyc;
    direction = dir;
    last_reg  = x[3:0];
    base_addr = base;
    start     = 1'b1;
    for (int i = 0; i <= x; i++) begin
      logic [11:0] a;
      a = base + 12'(i);
      if (!dir) begin
        push(K_MEMW, a, rf_m[i], k + 2 + 2*i);
      end else begin
        push(K_MEMR, a, 8'd0, k + 1 + 2*i);
        push(K_RFW, 12'(i), mem_m[a], k + 2 + 2*i);
      end
    end
    push(K_DONE, exp_inext, 8'd0, k + 2*(x+1) + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL drain_timeout: %0d events outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, rf_select_output, rf_write_enable, rf_select_input,
                rf_input_data, mem_addr, mem_read_enable, mem_write_enable,
                mem_write_data, i_next});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b0; start = 1'b0; direction = 1'b0; last_reg = 4'd0; base_addr = '0;
    for (int i = 0; i < 4096; i++) mem_m[i] = 8'd0;
    for (int i = 0; i < 16; i++) mem_m[12'h200 + i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 16; i++) rf_m[i] = 8'd0;
    rf_m[0] = 8'h11; rf_m[1] = 8'h22; rf_m[2] = 8'h33; rf_m[3] = 8'h44;

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);

    // Store X=3 at 0x300, start offered on the first edge after release.
    reset = 1'b1;
    start_xfer(1'b0, 3, 12'h300, 12'h304, k);
    drain(100);
    chk("store_mem300", 64'(mem_m[12'h300]), 64'h11);
    chk("store_mem301", 64'(mem_m[12'h301]), 64'h22);
    chk("store_mem302", 64'(mem_m[12'h302]), 64'h33);
    chk("store_mem303", 64'(mem_m[12'h303]), 64'h44);
    chk("store_inext_held", 64'(i_next), 64'h304);

    // Load X=15 from 0x200.
    start_xfer(1'b1, 15, 12'h200, 12'h210, k);
    drain(100);
    for (int i = 0; i < 16; i++) chk("load_rf", 64'(rf_m[i]), 64'(8'hA0 + 8'(i)));

    // Store X=1 at 0xFFF wraps to 0x000.
    start_xfer(1'b0, 1, 12'hFFF, 12'h001, k);
    drain(100);
    chk("wrap_memFFF", 64'(mem_m[12'hFFF]), 64'hA0);
    chk("wrap_mem000", 64'(mem_m[12'h000]), 64'hA1);

    // Load X=0 from 0x300.
    start_xfer(1'b1, 0, 12'h300, 12'h301, k);
    drain(100);
    chk("x0_rf0", 64'(rf_m[0]), 64'h11);
    chk("x0_rf1_untouched", 64'(rf_m[1]), 64'hA1);

    // Start re-pulsed mid-transfer and held across DONE must be ignored.
    for (int i = 0; i < 16; i++) rf_m[i] = 8'h50 + 8'(i);
    start_xfer(1'b0, 2, 12'h600, 12'h603, k);
    base_addr = 12'h7F0;
    while (cyc < k + 3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 6) @(negedge clk);
    start = 1'b1;
    while (cyc < k + 8) @(negedge clk);
    start = 1'b0;
    drain(100);
    chk("busy_mem600", 64'(mem_m[12'h600]), 64'h50);
    chk("busy_mem602", 64'(mem_m[12'h602]), 64'h52);
    chk("busy_no_second", 64'(mem_m[12'h7F0]), 64'h00);

    // Reset during the third S_WR of an X=7 store.
    start_xfer(1'b0, 7, 12'h500, 12'h508, k);
    while (sb.size() > 3) void'(sb.pop_back());
    while (cyc < k + 6) @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("reset_abort_outputs", all_outs(), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start_xfer(1'b0, 0, 12'h700, 12'h701, k);
    drain(100);
    chk("abort_mem500", 64'(mem_m[12'h500]), 64'h50);
    chk("abort_mem501", 64'(mem_m[12'h501]), 64'h51);
    for (int i = 3; i < 8; i++) chk("abort_untouched", 64'(mem_m[12'h500 + 12'(i)]), 64'h00);
    chk("post_reset_mem700", 64'(mem_m[12'h700]), 64'h50);
    chk("post_reset_inext", 64'(i_next), 64'h701);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chip8_reg_transfer.md
CHIP8_REG_TRANSFER -- requirements
Module: chip8_reg_transfer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, memory address width.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a transfer; sampled only in IDLE.
REQ-005 SHALL have port direction  input  1  0 = store V0..VX to memory (FX55), 1 = load memory into V0..VX (FX65).
REQ-006 SHALL have port last_reg  input  4  X, the index of the last register transferred.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  I, the memory address of V0.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port i_next  output  ADDR_WIDTH  updated I value, base_addr+last_reg+1.
REQ-011 SHALL have port rf_select_output  output  4  register file read select.
REQ-012 SHALL have port rf_output_data  input  8  register file read data; valid 1 cycle after select.
REQ-013 SHALL have port rf_write_enable  output  1  register file write strobe.
REQ-014 SHALL have port rf_select_input  output  4  register file write select.
REQ-015 SHALL have port rf_input_data  output  8  register file write data.
REQ-016 SHALL have port mem_addr  output  ADDR_WIDTH  memory address.
REQ-017 SHALL have port mem_read_enable  output  1  memory read strobe; data valid next cycle.
REQ-018 SHALL have port mem_read_data  input  8  memory read data.
REQ-019 SHALL have port mem_write_enable  output  1  memory write strobe.
REQ-020 SHALL have port mem_write_data  output  8  memory write data.

Function
REQ-021 SHALL implement states IDLE, S_RD, S_WR, L_RD, L_WR, DONE.
REQ-022 In IDLE with start=1, SHALL latch direction, last_reg, base_addr, clear index idx to 0, and go to S_RD (direction=0) or L_RD (direction=1).
REQ-023 S_RD SHALL drive rf_select_output=idx, with no strobes asserted, then go to S_WR.
REQ-024 S_WR SHALL drive mem_write_enable=1, mem_addr=base+idx, and mem_write_data=rf_output_data.
REQ-025 L_RD SHALL drive mem_read_enable=1 and mem_addr=base+idx, then go to L_WR.
REQ-026 L_WR SHALL drive rf_write_enable=1, rf_select_input=idx, and rf_input_data=mem_read_data.
REQ-027 On leaving S_WR or L_WR: if idx==last, SHALL go to DONE; else SHALL increment idx and return to S_RD or L_RD respectively.
REQ-028 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-029 Each register SHALL take exactly 2 cycles, so a transfer takes 2*(X+1) cycles plus the DONE cycle.
REQ-030 Address arithmetic SHALL be modulo 2^ADDR_WIDTH (base 0xFFF, idx 1 -> 0x000).
REQ-031 i_next SHALL be updated on entry to DONE to (base+last+1) mod 2^ADDR_WIDTH, and held until the next DONE.
REQ-032 start SHALL be ignored while busy, including in the DONE cycle.
REQ-033 Outside their active state, all strobes SHALL be 0; data and address outputs are don't-care but SHALL not cause writes.
REQ-034 last_reg=15 SHALL transfer all 16 registers; idx SHALL never exceed latched last.
REQ-035 At most one of rf_write_enable, mem_write_enable, and mem_read_enable SHALL be high in any cycle.

Reset
REQ-036 While reset=0, SHALL force state IDLE and idx=0.
REQ-037 While reset=0, busy, done, all strobes, all selects, all addresses, all data outputs, and i_next SHALL be 0.
REQ-038 Reset asserted mid-transfer SHALL abort the transfer immediately, issue no further strobes, and produce no done pulse.
REQ-039 After reset release, the block SHALL accept start on the first rising edge.

Verification
REQ-040 Store test: V0..V3=0x11,0x22,0x33,0x44, base=0x300, X=3, dir=0 -> memory writes 0x300..0x303 carry those bytes; done at cycle 9 after start; i_next=0x304.
REQ-041 Load test: mem 0x200..0x20F=0xA0..0xAF, X=15, dir=1 -> V0..VF=0xA0..0xAF; 16 rf writes; i_next=0x210.
REQ-042 Wrap test: base=0xFFF, X=1, store -> writes at 0xFFF then 0x000; i_next=0x001.
REQ-043 X=0 test: single register transferred; done at cycle 3; exactly one strobe pulse.
REQ-044 Busy test: start pulsed again during a transfer and during DONE -> ignored; no second transfer.
REQ-045 Reset test: reset driven low during the third S_WR of an X=7 store -> outputs 0 asynchronously; no done; memory beyond third write untouched; subsequent start works.
